insmem_boot_ctl: RTL and testbench

Boot and program-load controller for the 8-bit core. Owns the instruction-memory address/write port and arbitrates it between a host loader (16-bit words over a valid/ready handshake) and the core PC. Holds the core stalled while a program is streamed into instruction memory from address 0, waits a settle interval, then releases the core to fetch via the PC. Also handles run/halt requests and overflow errors.

---
 rtl/insmem_boot_ctl.sv | 81 ++++++++
 tb/tb_insmem_boot_ctl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/insmem_boot_ctl.sv
// insmem_boot_ctl: boot/program-load controller arbitrating the instruction-memory port
// between a host loader and the core PC.
//   clka, reset           : clock, async active-high reset
//   start_load/run_req/halt_req : session control pulses
//   host_valid/host_data/host_last/host_ready : host word stream (valid/ready)
//   pc                    : core program counter
//   mem_addr/mem_wdata/mem_we : instruction-memory write/address port
//   core_hold, busy, done, err_overflow, load_count : status
module insmem_boot_ctl #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 64,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              start_load,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   load_count
);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, ERROR} state_t;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    state_t state, state_n;
    logic [ADDR_W:0] wptr;
    logic [3:0] cnt;
    logic accept;
    assign accept = host_valid && state == LOAD;
    // The write pointer doubles as the word count; it holds until the next session starts.
    assign load_count = wptr;
    assign mem_wdata = host_data;
    always_comb begin
        state_n    = state;
        host_ready = state == LOAD;
        busy       = state == LOAD || state == SETTLE;
        core_hold  = state != RUN;
        mem_we     = accept;
        mem_addr   = state == LOAD ? wptr[ADDR_W-1:0] : pc;
        case (state)
            IDLE:    state_n = start_load ? LOAD : run_req ? SETTLE : IDLE;
            LOAD:    if (accept) state_n = host_last ? SETTLE : wptr == LAST ? ERROR : LOAD;
            SETTLE:  state_n = halt_req ? IDLE : cnt == 4'd0 ? RUN : SETTLE;
            RUN:     state_n = start_load ? LOAD : halt_req ? IDLE : RUN;
            ERROR:   state_n = start_load ? LOAD : ERROR;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wptr         <= '0;
            cnt          <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_n;
            done  <= state_n == RUN && state != RUN;
            // Reloaded in every other state so SETTLE always lasts SETTLE_CYC cycles.
            cnt   <= state == SETTLE ? cnt - 4'd1 : 4'(SETTLE_CYC - 1);
            if (state != LOAD && state_n == LOAD) begin
                wptr         <= '0;
                err_overflow <= 1'b0;
            end else begin
                if (accept) wptr <= wptr + 1'b1;
                if (state_n == ERROR) err_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_insmem_boot_ctl.sv
// tb_insmem_boot_ctl: randomized self-checking bench against a memory-image reference model.
module tb_insmem_boot_ctl;
    localparam int ADDR_W = 6, DATA_W = 16, DEPTH = 64, SETTLE_CYC = 2;
    logic clka = 0, reset = 1;
    logic start_load = 0, run_req = 0, halt_req = 0;
    logic host_valid = 0, host_last = 0, host_ready;
    logic [DATA_W-1:0] host_data = '0, mem_wdata;
    logic [ADDR_W-1:0] pc = 6'h15, mem_addr;
    logic mem_we, core_hold, busy, done, err_overflow;
    logic [ADDR_W:0] load_count;
    int errs = 0, checks = 0;
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [ADDR_W+DATA_W-1:0] wq[$];

    insmem_boot_ctl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clka(clka), .reset(reset), .start_load(start_load), .run_req(run_req), .halt_req(halt_req),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last), .host_ready(host_ready),
        .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .core_hold(core_hold),
        .busy(busy), .done(done), .err_overflow(err_overflow), .load_count(load_count));

    always #5 clka = ~clka;

    always @(negedge clka) if (mem_we) wq.push_back({mem_addr, mem_wdata});

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h need %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic noise(input bit on);
        start_load = on ? 1'($urandom_range(0, 1)) : 1'b0;
        run_req    = on ? 1'($urandom_range(0, 1)) : 1'b0;
        halt_req   = on ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic load_words(input int n, input bit use_last, input int maxgap, input int fixgap);
        wq.delete();
        start_load = 1;
        step();
        start_load = 0;
        chk("ready_in_load", 32'(host_ready), 1);
        chk("lc_cleared", 32'(load_count), 0);
        chk("err_cleared", 32'(err_overflow), 0);
        for (int i = 0; i < n; i++) begin
            repeat (fixgap >= 0 ? fixgap : $urandom_range(0, maxgap)) begin
                host_valid = 0;
                noise(1);
                step();
            end
            exp_mem[i] = DATA_W'($urandom);
            host_data  = exp_mem[i];
            host_valid = 1;
            host_last  = use_last && i == n - 1;
            noise(1);
            step();
        end
        host_valid = 0;
        host_last  = 0;
        noise(0);
        chk("n_writes", 32'(wq.size()), 32'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk("wr_addr", 32'(wq[i][ADDR_W+DATA_W-1:DATA_W]), 32'(i));
            chk("wr_data", 32'(wq[i][DATA_W-1:0]), 32'(exp_mem[i]));
        end
        chk("load_count", 32'(load_count), 32'(n));
    endtask

    task automatic settle_and_run(input int lc);
        int k = 0;
        chk("settle_busy", 32'(busy), 1);
        chk("settle_ready", 32'(host_ready), 0);
        while (core_hold && k < 20) begin
            chk("no_early_done", 32'(done), 0);
            step();
            k++;
        end
        chk("settle_len", 32'(k), SETTLE_CYC);
        chk("done_pulse", 32'(done), 1);
        chk("busy_run", 32'(busy), 0);
        step();
        chk("done_once", 32'(done), 0);
        chk("lc_held", 32'(load_count), 32'(lc));
        for (int i = 0; i < 3; i++) begin
            pc = ADDR_W'($urandom);
            #1;
            chk("addr_pc", 32'(mem_addr), 32'(pc));
            chk("run_no_we", 32'(mem_we), 0);
        end
    endtask

    initial begin
        #2;
        chk("rst_hold", 32'(core_hold), 1);
        chk("rst_ready", 32'(host_ready), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_lc", 32'(load_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_overflow), 0);
        chk("rst_addr", 32'(mem_addr), 32'h15);
        step();
        reset = 0;
        step();
        // normal load, continuous valid
        load_words(3, 1, 0, 0);
        settle_and_run(3);
        // fixed 2-cycle gaps, then random gaps
        load_words(3, 1, 0, 2);
        settle_and_run(3);
        load_words(5, 1, 3, -1);
        settle_and_run(5);
        // halt in RUN, then run_req reuses memory
        halt_req = 1;
        step();
        halt_req = 0;
        chk("halt_hold", 32'(core_hold), 1);
        chk("halt_busy", 32'(busy), 0);
        run_req = 1;
        step();
        run_req = 0;
        settle_and_run(5);
        // halt during SETTLE returns to idle without running
        halt_req = 1;
        step();
        halt_req = 0;
        run_req = 1;
        step();
        run_req = 0;
        halt_req = 1;
        step();
        halt_req = 0;
        repeat (4) step();
        chk("settle_halt_hold", 32'(core_hold), 1);
        chk("settle_halt_busy", 32'(busy), 0);
        chk("settle_halt_done", 32'(done), 0);
        // full memory with last on the final word is a legal program
        load_words(DEPTH, 1, 1, -1);
        settle_and_run(DEPTH);
        // overflow
        load_words(DEPTH, 0, 0, 0);
        chk("ovf_err", 32'(err_overflow), 1);
        chk("ovf_ready", 32'(host_ready), 0);
        chk("ovf_hold", 32'(core_hold), 1);
        chk("ovf_busy", 32'(busy), 0);
        host_valid = 1;
        run_req = 1;
        halt_req = 1;
        repeat (3) step();
        host_valid = 0;
        run_req = 0;
        halt_req = 0;
        chk("ovf_no_extra_wr", 32'(wq.size()), DEPTH);
        chk("ovf_sticky", 32'(err_overflow), 1);
        chk("ovf_hold2", 32'(core_hold), 1);
        load_words(2, 1, 2, -1);
        settle_and_run(2);
        // reset mid-load
        wq.delete();
        start_load = 1;
        step();
        start_load = 0;
        for (int i = 0; i < 5; i++) begin
            host_data  = DATA_W'($urandom);
            host_valid = 1;
            step();
        end
        #2;
        reset = 1;
        #1;
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_lc", 32'(load_count), 0);
        chk("mid_rst_ready", 32'(host_ready), 0);
        chk("mid_rst_hold", 32'(core_hold), 1);
        chk("mid_rst_nwr", 32'(wq.size()), 5);
        host_valid = 0;
        step();
        reset = 0;
        step();
        load_words(4, 1, 2, -1);
        settle_and_run(4);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
